shift_reg_univ: RTL and testbench

- Parametrised N-bit universal register; successor to the plain N-bit enabled D flip-flop bank (PIPO).
- Adds mode-selected parallel load, logical shift left/right with serial inputs, rotate left/right, and synchronous clear.
- Adds a shift counter with a DONE flag, so the same block serves as a PIPO, SIPO, PISO or SISO stage in serial-link tasks.

---
 rtl/shift_reg_pkg.sv | 33 +++
 rtl/shift_cnt.sv | 43 ++++
 rtl/shift_reg_univ.sv | 78 +++++++
 tb/tb_shift_reg_univ.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Operation encoding and helpers for the universal register.
//  Revision    : 1.0
// ============================================================================
package shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        CLR  = 3'd6,
        RSVD = 3'd7
    } mode_t;

    // Shifts and rotates are the only operations that advance the shift count.
    function automatic logic is_shift(input mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
    endfunction

    // LOAD and CLR restart the shift count.
    function automatic logic is_restart(input mode_t m);
        return (m == LOAD) || (m == CLR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : shift_cnt
//  Description : Saturating up-counter with synchronous active-low reset,
//                clear, increment enable and an at-max flag.
//  Revision    : 1.0
// ============================================================================
module shift_cnt #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          CLK,
    input  logic          N_RESET,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt,
    output logic          o_done
);

    localparam logic [CW-1:0] c_max = CW'(MAX);
    localparam logic [CW-1:0] c_one = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == c_max);

    // Clear outranks increment; the count sticks at MAX instead of wrapping.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = w_at_max;

endmodule
`default_nettype wire

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_univ
//  Description : N-bit universal register: load, shift, rotate, clear, with a
//                saturating shift counter and DONE flag for serial links.
//  Revision    : 1.0
// ============================================================================
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic [N-1:0]      D,
    input  logic              SER_IN_L,
    input  logic              SER_IN_R,
    output logic [N-1:0]      Q,
    output logic              SER_OUT_L,
    output logic              SER_OUT_R,
    output logic [CW-1:0]     CNT,
    output logic              DONE
);

    mode_t        w_mode;
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_next;
    logic         w_cnt_clr;
    logic         w_cnt_inc;

    assign w_mode = mode_t'(MODE);

    // HOLD and the reserved code both fall through to the default hold.
    always_comb begin
        w_q_next = r_q;
        case (w_mode)
            LOAD:    w_q_next = D;
            SHL:     w_q_next = {r_q[N-2:0], SER_IN_L};
            SHR:     w_q_next = {SER_IN_R, r_q[N-1:1]};
            ROL:     w_q_next = {r_q[N-2:0], r_q[N-1]};
            ROR:     w_q_next = {r_q[0], r_q[N-1:1]};
            CLR:     w_q_next = '0;
            default: w_q_next = r_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_q <= '0;
        end else if (EN) begin
            r_q <= w_q_next;
        end
    end

    assign w_cnt_clr = EN && is_restart(w_mode);
    assign w_cnt_inc = EN && is_shift(w_mode);

    shift_cnt #(
        .MAX (N),
        .CW  (CW)
    ) u_shift_cnt (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_cnt   (CNT),
        .o_done  (DONE)
    );

    assign Q         = r_q;
    assign SER_OUT_L = r_q[N-1];
    assign SER_OUT_R = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_univ
//  Description : Directed and randomized self-checking bench for shift_reg_univ.
//  Revision    : 1.0
// ============================================================================
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    localparam int N   = 8;
    localparam int CW  = $clog2(N + 1);
    localparam int POW = 1 << N;

    logic          CLK = 1'b0;
    logic          N_RESET = 1'b1;
    logic          EN = 1'b0;
    logic [2:0]    MODE = 3'd0;
    logic [N-1:0]  D = '0;
    logic          SER_IN_L = 1'b0;
    logic          SER_IN_R = 1'b0;
    logic [N-1:0]  Q;
    logic          SER_OUT_L;
    logic          SER_OUT_R;
    logic [CW-1:0] CNT;
    logic          DONE;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: register value and shift count as plain integers.
    int mq = 0;
    int mc = 0;

    // Inputs latched at drive time so the model sees what the DUT samples.
    logic       s_nr, s_en, s_sl, s_sr;
    logic [2:0] s_mode;
    logic [7:0] s_d;

    shift_reg_univ #(.N(N)) dut (
        .CLK       (CLK),
        .N_RESET   (N_RESET),
        .EN        (EN),
        .MODE      (MODE),
        .D         (D),
        .SER_IN_L  (SER_IN_L),
        .SER_IN_R  (SER_IN_R),
        .Q         (Q),
        .SER_OUT_L (SER_OUT_L),
        .SER_OUT_R (SER_OUT_R),
        .CNT       (CNT),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        int m;
        m = int'(s_mode);
        if (!s_nr) begin
            mq = 0;
            mc = 0;
        end else if (s_en) begin
            if (m == 1) begin
                mq = int'(s_d);
                mc = 0;
            end else if (m == 6) begin
                mq = 0;
                mc = 0;
            end else if (m >= 2 && m <= 5) begin
                case (m)
                    2:       mq = (mq * 2) % POW + int'(s_sl);
                    3:       mq = mq / 2 + int'(s_sr) * (POW / 2);
                    4:       mq = (mq * 2) % POW + mq / (POW / 2);
                    default: mq = mq / 2 + (mq % 2) * (POW / 2);
                endcase
                mc = (mc + 1 > N) ? N : mc + 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(Q),         32'(mq));
        check({tag, ".cnt"},  32'(CNT),       32'(mc));
        check({tag, ".done"}, 32'(DONE),      32'(mc == N));
        check({tag, ".sol"},  32'(SER_OUT_L), 32'((mq / (POW / 2)) % 2));
        check({tag, ".sor"},  32'(SER_OUT_R), 32'(mq % 2));
    endtask

    task automatic drive(input logic nr, input logic en, input logic [2:0] mode,
                         input logic [7:0] d, input logic sl, input logic sr);
        @(negedge CLK);
        N_RESET = nr; EN = en; MODE = mode; D = d; SER_IN_L = sl; SER_IN_R = sr;
        s_nr = nr; s_en = en; s_mode = mode; s_d = d; s_sl = sl; s_sr = sr;
    endtask

    task automatic edge_check(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic apply(input logic nr, input logic en, input logic [2:0] mode,
                         input logic [7:0] d, input logic sl, input logic sr,
                         input string tag);
        drive(nr, en, mode, d, sl, sr);
        edge_check(tag);
    endtask

    initial begin
        logic [7:0]    piso_seq;
        logic [7:0]    sipo_bits;
        logic [N-1:0]  q_frozen;
        logic [CW-1:0] c_frozen;

        piso_seq  = 8'b1011_0100;
        sipo_bits = 8'b0101_0011;

        // Reset wins over EN/LOAD.
        apply(1'b0, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, "rst");
        check("rst.q_zero", 32'(Q), 32'h00);
        check("rst.cnt_zero", 32'(CNT), 32'h0);
        check("rst.done_low", 32'(DONE), 32'h0);

        // Reset low between edges leaves Q alone until the next edge.
        apply(1'b1, 1'b1, LOAD, 8'h5A, 1'b0, 1'b0, "pre_sync");
        drive(1'b0, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
        #2;
        check("rst_sync_hold.q", 32'(Q), 32'h5A);
        edge_check("rst_sync");
        check("rst_sync.q_zero", 32'(Q), 32'h00);

        // PIPO and hold behaviour.
        apply(1'b1, 1'b1, LOAD, 8'hA5, 1'b0, 1'b0, "load_a5");
        check("load_a5.q", 32'(Q), 32'hA5);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, LOAD, 8'h3C, 1'b0, 1'b0, "en_low");
        check("en_low.q", 32'(Q), 32'hA5);
        apply(1'b1, 1'b1, RSVD, 8'h3C, 1'b1, 1'b1, "rsvd");
        check("rsvd.q", 32'(Q), 32'hA5);
        apply(1'b1, 1'b1, HOLD, 8'h3C, 1'b1, 1'b1, "hold");

        // PISO: MSB appears on SER_OUT_L before the first shift edge.
        apply(1'b1, 1'b1, LOAD, 8'hB4, 1'b0, 1'b0, "piso_load");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, SHL, 8'h00, 1'b0, 1'b0);
            #1;
            check("piso.pre_edge_sol", 32'(SER_OUT_L), 32'(piso_seq[7-i]));
            edge_check("piso");
        end
        check("piso.q", 32'(Q), 32'h00);
        check("piso.cnt", 32'(CNT), 32'd8);
        check("piso.done", 32'(DONE), 32'h1);
        apply(1'b1, 1'b1, SHL, 8'h00, 1'b0, 1'b0, "piso_sat");
        check("piso_sat.cnt", 32'(CNT), 32'd8);

        // SIPO with an enable gap after the fourth shift.
        apply(1'b1, 1'b1, CLR, 8'hFF, 1'b1, 1'b1, "sipo_clr");
        check("sipo_clr.q", 32'(Q), 32'h00);
        check("sipo_clr.cnt", 32'(CNT), 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                q_frozen = Q;
                c_frozen = CNT;
                for (int k = 0; k < 2; k++) apply(1'b1, 1'b0, SHR, 8'h00, 1'b1, ~sipo_bits[i], "sipo_gap");
                check("sipo_gap.q", 32'(Q), 32'(q_frozen));
                check("sipo_gap.cnt", 32'(CNT), 32'd4);
                check("sipo_gap.cnt_frozen", 32'(CNT), 32'(c_frozen));
            end
            apply(1'b1, 1'b1, SHR, 8'h00, 1'b0, sipo_bits[i], "sipo");
        end
        check("sipo.q", 32'(Q), 32'h53);
        check("sipo.done", 32'(DONE), 32'h1);

        // Rotates.
        apply(1'b1, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, "rot_load");
        apply(1'b1, 1'b1, ROL, 8'h00, 1'b0, 1'b0, "rol1");
        check("rol1.q", 32'(Q), 32'h03);
        for (int i = 0; i < 2; i++) apply(1'b1, 1'b1, ROR, 8'h00, 1'b1, 1'b1, "ror");
        check("ror2.q", 32'(Q), 32'hC0);
        check("ror2.cnt", 32'(CNT), 32'd3);
        apply(1'b1, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, "rot_load2");
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, ROL, 8'h00, 1'b0, 1'b0, "rol8");
        check("rol8.q", 32'(Q), 32'h81);
        check("rol8.done", 32'(DONE), 32'h1);

        // Reset in the middle of a shift sequence.
        apply(1'b1, 1'b1, LOAD, 8'hF0, 1'b0, 1'b0, "mid_load");
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, SHL, 8'h00, 1'b1, 1'b0, "mid_shl");
        apply(1'b0, 1'b1, SHL, 8'h00, 1'b1, 1'b0, "mid_rst");
        check("mid_rst.q", 32'(Q), 32'h00);
        check("mid_rst.cnt", 32'(CNT), 32'h0);
        check("mid_rst.done", 32'(DONE), 32'h0);
        apply(1'b1, 1'b1, LOAD, 8'h0F, 1'b0, 1'b0, "post_rst");
        check("post_rst.q", 32'(Q), 32'h0F);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply(logic'($urandom_range(0, 24) != 0),
                  logic'($urandom_range(0, 5) != 0),
                  3'($urandom_range(0, 7)),
                  8'($urandom),
                  1'($urandom),
                  1'($urandom),
                  "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
